mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single-port system RAM between the 6502 CPU and the VIC video-fetch engine, following C64 BA/RDY semantics.
- Sits between the `_6502` core, the VIC fetch unit and the RAM, which has a registered address and one-cycle read latency.
- Warns the CPU a fixed number of cycles before stealing the bus, then grants the VIC a bounded burst.
- After each burst, guarantees the CPU a minimum number of bus cycles before the next steal.

Parameters:
- BA_LEAD, 3, number of warning cycles with cpu_rdy low before the VIC owns the bus (must be ≥1).
- MAX_BURST, 40, maximum consecutive VIC access cycles per grant.
- CPU_MIN, 2, minimum CPU-owned cycles after a release before vic_req is honoured again.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_ab  in  16  CPU address.
- cpu_do  in  8  CPU write data.
- cpu_we  in  1  CPU write enable.
- cpu_di  out  8  read data returned to the CPU.
- cpu_rdy  out  1  high means the CPU owns the bus; low means the CPU must stall its read cycles.
- vic_req  in  1  VIC requests bus cycles; held high for the duration of the burst.
- vic_ab  in  16  VIC fetch address.
- vic_grant  out  1  the current cycle is a VIC RAM access.
- vic_di  out  8  VIC read data.
- vic_valid  out  1  vic_di holds the data for the previous granted cycle.
- ram_ab  out  16  RAM address.
- ram_do  out  8  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_di  in  8  RAM read data, valid one cycle after ram_ab.

Behaviour:
- States: CPU, WARN, VIC, REL. Reset (reset=0, asynchronous) forces the following:
  - state=CPU, all counters cleared.
  - cpu_rdy=1, vic_grant=0, vic_valid=0, cpu_di=0.
  - ram_we=0 while reset is low.
  - Any burst in progress is aborted with no further VIC cycles.
- Bus mux (combinational):
  - In CPU and WARN: ram_ab=cpu_ab, ram_do=cpu_do, ram_we=cpu_we.
  - In VIC and REL: ram_ab=vic_ab and ram_we=0. No VIC write path exists.
- cpu_rdy=1 only in CPU state. In WARN the CPU bus still drives RAM, so in-progress 6502 write cycles complete; CPU reads must stall.
- cpu_di:
  - Registered copy of ram_di, updated only on cycles following a CPU-driven address.
  - Otherwise cpu_di holds its value, so the CPU sees stable data across a stall.
- vic_di=ram_di.
- vic_valid is registered: it equals vic_grant delayed by one cycle.
- CPU state:
  - A holdoff counter is loaded with CPU_MIN on entry from REL and decrements to 0.
  - If vic_req=1 and holdoff=0 at a rising edge, go to WARN and load warn count=BA_LEAD-1.
- WARN state:
  - If vic_req=0 at an edge, return to CPU (abort); no VIC cycle occurs and cpu_rdy is high the next cycle.
  - If warn count=0 at an edge, go to VIC with burst count=0. Otherwise decrement the warn count.
  - WARN lasts exactly BA_LEAD cycles when not aborted.
- VIC state:
  - vic_grant = vic_req.
  - Each granted cycle increments the burst count.
  - Go to REL at the edge where vic_req=0 or burst count=MAX_BURST-1.
  - At most MAX_BURST grants occur per visit.
- REL state:
  - Lasts one cycle: cpu_rdy=0, vic_grant=0; the final vic_valid is delivered here.
  - Then go to CPU with holdoff=CPU_MIN.
- A vic_req held continuously therefore yields repeating cycles of: CPU_MIN CPU cycles, BA_LEAD WARN, MAX_BURST VIC, 1 REL.
- Counter widths are sized by clog2 of the respective parameter.

Test Plan:
1. **CPU access after reset.** Release reset, then CPU writes 0x69 to 0x1300 and reads 0x1300 back. Required: cpu_di=0x69 one cycle after the read address; cpu_rdy=1 throughout; vic_grant=0.
2. **Basic VIC grant.** With ram[0x0400]=0x5A, sample vic_req=1 at edge T with vic_ab=0x0400. Required:
   - cpu_rdy=0 from T.
   - vic_grant=1 from T+3.
   - vic_valid=1 with vic_di=0x5A at T+4.
   - cpu_di keeps its pre-steal value during the stall.
3. **Write during WARN.** CPU writes 0xA5 to 0x0010 in the first WARN cycle. Required: ram[0x0010]=0xA5 afterwards; ram_we=0 for every VIC/REL cycle.
4. **Burst limit and holdoff.** Hold vic_req high for 60 cycles. Required:
   - Exactly 40 consecutive vic_grant cycles, then 1 REL cycle.
   - cpu_rdy=1 for exactly 2 cycles.
   - Then WARN for 3 cycles and a new grant sequence.
5. **Abort in WARN.** Drop vic_req during the second WARN cycle. Required: no vic_grant; cpu_rdy=1 from the next cycle; the next request is honoured without holdoff.
6. **Reset mid-burst.** Assert reset=0 on the 10th granted cycle. Required: vic_grant=0, cpu_rdy=1, ram_we=0 immediately (asynchronously); after release the state is CPU with no holdoff.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Shares the single-port system RAM between the 6502 CPU and the VIC fetch engine
// with C64-style BA/RDY: warn the CPU, grant a bounded VIC burst, then guarantee CPU cycles.
module mem_bus_arbiter #(
    parameter int BA_LEAD   = 3,
    parameter int MAX_BURST = 40,
    parameter int CPU_MIN   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_ab,
    input  logic [7:0]  cpu_do,
    input  logic        cpu_we,
    output logic [7:0]  cpu_di,
    output logic        cpu_rdy,
    input  logic        vic_req,
    input  logic [15:0] vic_ab,
    output logic        vic_grant,
    output logic [7:0]  vic_di,
    output logic        vic_valid,
    output logic [15:0] ram_ab,
    output logic [7:0]  ram_do,
    output logic        ram_we,
    input  logic [7:0]  ram_di
);
    localparam int WARN_W  = (BA_LEAD   > 1) ? $clog2(BA_LEAD)     : 1;
    localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST)   : 1;
    localparam int HOLD_W  = (CPU_MIN   > 0) ? $clog2(CPU_MIN + 1) : 1;

    typedef enum logic [1:0] {S_CPU, S_WARN, S_VIC, S_REL} state_e;

    state_e             state_q;
    logic [WARN_W-1:0]  warn_q;
    logic [BURST_W-1:0] burst_q;
    logic [HOLD_W-1:0]  holdoff_q;
    logic [HOLD_W-1:0]  holdoff_d;
    logic               cpu_rdy_q;
    logic               vic_valid_q;
    logic               cpu_phase_q;
    logic [7:0]         cpu_di_q;
    logic               cpu_side;

    assign cpu_side  = (state_q == S_CPU) || (state_q == S_WARN);
    assign ram_ab    = cpu_side ? cpu_ab : vic_ab;
    assign ram_do    = cpu_do;
    // NOTE: gated with reset itself so no CPU write can reach RAM while reset is held low.
    assign ram_we    = cpu_side && cpu_we && reset;
    assign vic_grant = (state_q == S_VIC) && vic_req;
    assign vic_di    = ram_di;
    assign vic_valid = vic_valid_q;
    assign cpu_rdy   = cpu_rdy_q;

    // Fresh RAM data flows through after a CPU-addressed cycle; otherwise the last value is replayed.
    assign cpu_di    = cpu_phase_q ? ram_di : cpu_di_q;

    assign holdoff_d = (holdoff_q != '0) ? holdoff_q - HOLD_W'(1) : holdoff_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_CPU;
            warn_q      <= '0;
            burst_q     <= '0;
            holdoff_q   <= '0;
            cpu_rdy_q   <= 1'b1;
            vic_valid_q <= 1'b0;
            cpu_phase_q <= 1'b0;
            cpu_di_q    <= '0;
        end else begin
            vic_valid_q <= vic_grant;
            cpu_phase_q <= cpu_side;
            cpu_di_q    <= cpu_di;

            case (state_q)
                S_CPU: begin
                    holdoff_q <= holdoff_d;
                    // NOTE: the decremented holdoff is tested so the CPU keeps the bus for exactly CPU_MIN cycles.
                    if (vic_req && (holdoff_d == '0)) begin
                        state_q   <= S_WARN;
                        warn_q    <= WARN_W'(BA_LEAD - 1);
                        cpu_rdy_q <= 1'b0;
                    end
                end
                S_WARN: begin
                    if (!vic_req) begin
                        state_q   <= S_CPU;
                        cpu_rdy_q <= 1'b1;
                    end else if (warn_q == '0) begin
                        state_q <= S_VIC;
                        burst_q <= '0;
                    end else begin
                        warn_q <= warn_q - WARN_W'(1);
                    end
                end
                S_VIC: begin
                    if (vic_req) begin
                        burst_q <= burst_q + BURST_W'(1);
                    end
                    if (!vic_req || (burst_q == BURST_W'(MAX_BURST - 1))) begin
                        state_q <= S_REL;
                    end
                end
                S_REL: begin
                    state_q   <= S_CPU;
                    holdoff_q <= HOLD_W'(CPU_MIN);
                    cpu_rdy_q <= 1'b1;
                end
                default: begin
                    state_q   <= S_CPU;
                    cpu_rdy_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a vector table for CPU access, VIC grant and WARN writes,
// plus hand-written sequences for burst limit/holdoff, WARN abort and reset mid-burst.
module tb_mem_bus_arbiter;
    localparam int BA_LEAD   = 3;
    localparam int MAX_BURST = 40;
    localparam int CPU_MIN   = 2;
    localparam int PERIOD    = BA_LEAD + MAX_BURST + 1 + CPU_MIN;

    logic        clk;
    logic        reset;
    logic [15:0] cpu_ab;
    logic [7:0]  cpu_do;
    logic        cpu_we;
    logic [7:0]  cpu_di;
    logic        cpu_rdy;
    logic        vic_req;
    logic [15:0] vic_ab;
    logic        vic_grant;
    logic [7:0]  vic_di;
    logic        vic_valid;
    logic [15:0] ram_ab;
    logic [7:0]  ram_do;
    logic        ram_we;
    logic [7:0]  ram_di;

    int total = 0;
    int bad   = 0;

    mem_bus_arbiter #(
        .BA_LEAD  (BA_LEAD),
        .MAX_BURST(MAX_BURST),
        .CPU_MIN  (CPU_MIN)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cpu_ab   (cpu_ab),
        .cpu_do   (cpu_do),
        .cpu_we   (cpu_we),
        .cpu_di   (cpu_di),
        .cpu_rdy  (cpu_rdy),
        .vic_req  (vic_req),
        .vic_ab   (vic_ab),
        .vic_grant(vic_grant),
        .vic_di   (vic_di),
        .vic_valid(vic_valid),
        .ram_ab   (ram_ab),
        .ram_do   (ram_do),
        .ram_we   (ram_we),
        .ram_di   (ram_di)
    );

    always #5 clk = ~clk;

    // RAM model: registered address, data valid the cycle after the address.
    logic [7:0]  mem [0:65535];
    logic [15:0] ram_ab_q;
    always @(posedge clk) begin
        if (ram_we) mem[ram_ab] <= ram_do;
        ram_ab_q <= ram_ab;
    end
    assign ram_di = mem[ram_ab_q];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] cpu_ab;
        logic [7:0]  cpu_do;
        logic        cpu_we;
        logic        vic_req;
        logic        e_rdy;
        logic        e_grant;
        logic        e_valid;
        logic        e_we;
        logic        chk_di;
        logic [7:0]  e_di;
        logic        chk_vdi;
        logic [7:0]  e_vdi;
    } vec_t;

    vec_t vecs [21];

    // Expected {cpu_rdy, vic_grant} for cycle c of a continuously held request.
    function automatic logic [1:0] held_pattern(input int c);
        int p;
        if (c == 0) return 2'b10;
        p = (c - 1) % PERIOD;
        if (p < BA_LEAD) return 2'b00;
        if (p < BA_LEAD + MAX_BURST) return 2'b01;
        if (p == BA_LEAD + MAX_BURST) return 2'b00;
        return 2'b10;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] exp_rg;
        logic       prev_g;
        logic [7:0] t5_req;
        logic [7:0] t5_rdy;
        logic [7:0] t5_grant;

        for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
        mem[16'h0400] <= 8'h5A;

        //            cpu_ab    do     we    req   rdy   gnt   vld   r_we  chkdi  di     chkv  vdi
        vecs[0]  = '{16'h1300, 8'h69, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[1]  = '{16'h1300, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[2]  = '{16'h1300, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h69, 1'b0, 8'h00};
        vecs[3]  = '{16'h1300, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h69, 1'b0, 8'h00};
        vecs[4]  = '{16'h1300, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h69, 1'b0, 8'h00};
        vecs[5]  = '{16'h1300, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h69, 1'b0, 8'h00};
        vecs[6]  = '{16'h1300, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h69, 1'b0, 8'h00};
        vecs[7]  = '{16'h1300, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h69, 1'b0, 8'h00};
        vecs[8]  = '{16'h1300, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h69, 1'b1, 8'h5A};
        vecs[9]  = '{16'h1300, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h69, 1'b0, 8'h00};
        vecs[10] = '{16'h1300, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h69, 1'b0, 8'h00};
        vecs[11] = '{16'h1300, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h69, 1'b0, 8'h00};
        vecs[12] = '{16'h1300, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h69, 1'b0, 8'h00};
        vecs[13] = '{16'h0010, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h69, 1'b0, 8'h00};
        vecs[14] = '{16'h0010, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 8'h00};
        vecs[15] = '{16'h0010, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 8'h00};
        vecs[16] = '{16'h0010, 8'hEE, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 8'h00};
        vecs[17] = '{16'h0010, 8'hEE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 8'h5A};
        vecs[18] = '{16'h0010, 8'hEE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 8'h00};
        vecs[19] = '{16'h0010, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 8'h00};
        vecs[20] = '{16'h0010, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 8'h00};

        // Reset state, with a CPU write attempted while reset is low.
        clk     = 1'b0;
        reset   = 1'b0;
        cpu_ab  = 16'h1300;
        cpu_do  = 8'hFF;
        cpu_we  = 1'b1;
        vic_req = 1'b0;
        vic_ab  = 16'h0400;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset cpu_rdy",   16'(cpu_rdy),   16'd1);
        check("reset vic_grant", 16'(vic_grant), 16'd0);
        check("reset vic_valid", 16'(vic_valid), 16'd0);
        check("reset cpu_di",    16'(cpu_di),    16'h00);
        check("reset ram_we",    16'(ram_we),    16'd0);
        cpu_we = 1'b0;
        reset  = 1'b1;
        next_cycle();

        // CPU access, basic VIC grant, write during WARN.
        for (int i = 0; i < 21; i++) begin
            cpu_ab  = vecs[i].cpu_ab;
            cpu_do  = vecs[i].cpu_do;
            cpu_we  = vecs[i].cpu_we;
            vic_req = vecs[i].vic_req;
            @(negedge clk);
            check($sformatf("v%0d cpu_rdy", i),   16'(cpu_rdy),   16'(vecs[i].e_rdy));
            check($sformatf("v%0d vic_grant", i), 16'(vic_grant), 16'(vecs[i].e_grant));
            check($sformatf("v%0d vic_valid", i), 16'(vic_valid), 16'(vecs[i].e_valid));
            check($sformatf("v%0d ram_we", i),    16'(ram_we),    16'(vecs[i].e_we));
            if (vecs[i].chk_di)  check($sformatf("v%0d cpu_di", i), 16'(cpu_di), 16'(vecs[i].e_di));
            if (vecs[i].chk_vdi) check($sformatf("v%0d vic_di", i), 16'(vic_di), 16'(vecs[i].e_vdi));
            next_cycle();
        end

        // Request held for 60 cycles: burst limit, REL, CPU holdoff, next WARN and grant.
        cpu_ab = 16'h0010;
        cpu_we = 1'b0;
        prev_g = 1'b0;
        for (int c = 0; c < 60; c++) begin
            vic_req = 1'b1;
            @(negedge clk);
            exp_rg = held_pattern(c);
            check($sformatf("held c%0d rdy/grant", c), 16'({cpu_rdy, vic_grant}), 16'(exp_rg));
            check($sformatf("held c%0d vic_valid", c), 16'(vic_valid), 16'(prev_g));
            check($sformatf("held c%0d ram_we", c),    16'(ram_we),    16'd0);
            prev_g = exp_rg[0];
            next_cycle();
        end
        for (int c = 0; c < 6; c++) begin
            vic_req = 1'b0;
            @(negedge clk);
            if (c == 5) check("idle cpu_rdy", 16'(cpu_rdy), 16'd1);
            next_cycle();
        end

        // Abort in the second WARN cycle, then an immediate re-request with no holdoff.
        t5_req   = 8'b1111_1011;
        t5_rdy   = 8'b0000_1001;
        t5_grant = 8'b1000_0000;
        for (int a = 0; a < 8; a++) begin
            vic_req = t5_req[a];
            @(negedge clk);
            check($sformatf("abort a%0d cpu_rdy", a),   16'(cpu_rdy),   16'(t5_rdy[a]));
            check($sformatf("abort a%0d vic_grant", a), 16'(vic_grant), 16'(t5_grant[a]));
            next_cycle();
        end

        // Reset asserted asynchronously on the 10th granted cycle.
        for (int k = 8; k <= 16; k++) begin
            vic_req = 1'b1;
            if (k == 16) begin
                cpu_ab = 16'h0020;
                cpu_do = 8'h77;
                cpu_we = 1'b1;
            end
            @(negedge clk);
            check($sformatf("burst grant #%0d", k - 6), 16'(vic_grant), 16'd1);
            if (k < 16) next_cycle();
        end
        #1 reset = 1'b0;
        #1;
        check("async reset vic_grant", 16'(vic_grant), 16'd0);
        check("async reset cpu_rdy",   16'(cpu_rdy),   16'd1);
        check("async reset ram_we",    16'(ram_we),    16'd0);
        check("async reset vic_valid", 16'(vic_valid), 16'd0);
        check("async reset cpu_di",    16'(cpu_di),    16'h00);
        repeat (2) next_cycle();
        check("held reset ram_we",    16'(ram_we),    16'd0);
        check("held reset vic_grant", 16'(vic_grant), 16'd0);
        @(negedge clk);
        cpu_we = 1'b0;
        reset  = 1'b1;
        #1;
        check("post reset cpu_rdy", 16'(cpu_rdy), 16'd1);
        next_cycle();
        @(negedge clk);
        check("post reset no holdoff", 16'(cpu_rdy), 16'd0);
        check("post reset warn grant", 16'(vic_grant), 16'd0);
        vic_req = 1'b0;
        repeat (4) next_cycle();
        @(negedge clk);
        check("final cpu_rdy", 16'(cpu_rdy), 16'd1);
        check("mem 0x0010",    16'(mem[16'h0010]), 16'h00A5);
        check("mem 0x1300",    16'(mem[16'h1300]), 16'h0069);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
